// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcode/funct codes,
// ALU encodings, datapath selects, FSM state codes and per-state control word.
package multicycle_controller_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_NOR = 6'b100111;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALUOP_ADD = 4'b0110;
  localparam logic [3:0] ALUOP_SUB = 4'b1110;
  localparam logic [3:0] ALUOP_AND = 4'b0000;
  localparam logic [3:0] ALUOP_OR  = 4'b0001;
  localparam logic [3:0] ALUOP_XOR = 4'b0010;
  localparam logic [3:0] ALUOP_NOR = 4'b0011;
  localparam logic [3:0] ALUOP_SLT = 4'b1111;

  localparam logic [1:0] ALUSRCB_RT     = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_BRANCH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTEXE  = 4'd7,
    S_ALUWB  = 4'd8,
    S_IEXE   = 4'd9,
    S_IWB    = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12,
    S_HALT   = 4'd13
  } state_e;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [3:0] aluop;
    logic       sextend;
    logic       halted;
  } ctrl_t;

  // Moore part of the control word for a given state; the memory-handshake
  // and branch-condition terms are added combinationally in the top.
  function automatic ctrl_t state_ctrl(input state_e state, input logic [3:0] dec_aluop,
                                       input logic dec_sextend);
    ctrl_t c;
    c = '0;
    case (state)
      S_FETCH: begin
        c.memread = 1'b1;
        c.alusrcb = ALUSRCB_FOUR;
        c.aluop   = ALUOP_ADD;
        c.pcsrc   = PCSRC_ALU;
      end
      S_DECODE: begin
        c.alusrcb = ALUSRCB_BRANCH;
        c.aluop   = ALUOP_ADD;
        c.sextend = 1'b1;
      end
      S_RTEXE: begin
        c.alusrca = 1'b1;
        c.alusrcb = ALUSRCB_RT;
        c.aluop   = dec_aluop;
      end
      S_ALUWB: begin
        c.regwrite = 1'b1;
        c.regdst   = 1'b1;
      end
      S_IEXE: begin
        c.alusrca = 1'b1;
        c.alusrcb = ALUSRCB_IMM;
        c.aluop   = dec_aluop;
        c.sextend = dec_sextend;
      end
      S_IWB: c.regwrite = 1'b1;
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = ALUSRCB_IMM;
        c.aluop   = ALUOP_ADD;
        c.sextend = 1'b1;
      end
      S_MEMRD: begin
        c.memread = 1'b1;
        c.iord    = 1'b1;
      end
      S_MEMWB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        c.memwrite = 1'b1;
        c.iord     = 1'b1;
      end
      S_BRANCH: begin
        c.alusrca = 1'b1;
        c.alusrcb = ALUSRCB_RT;
        c.aluop   = ALUOP_SUB;
        c.pcsrc   = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        c.pcsrc = PCSRC_JUMP;
        c.pcen  = 1'b1;
      end
      S_HALT: c.halted = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: maps op/funct to ALU operation and immediate
// extension, and flags opcodes/functs the core does not implement.
module multicycle_controller_alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] aluop,
  output logic       sextend,
  output logic       illegal
);

  // NOTE: every output gets a default before the case so no path infers a latch.
  always_comb begin
    aluop   = ALUOP_ADD;
    sextend = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  aluop = ALUOP_ADD;
          FN_SUB:  aluop = ALUOP_SUB;
          FN_AND:  aluop = ALUOP_AND;
          FN_OR:   aluop = ALUOP_OR;
          FN_XOR:  aluop = ALUOP_XOR;
          FN_NOR:  aluop = ALUOP_NOR;
          FN_SLT:  aluop = ALUOP_SLT;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin
        aluop   = ALUOP_ADD;
        sextend = 1'b1;
      end
      OP_SLTI: begin
        aluop   = ALUOP_SLT;
        sextend = 1'b1;
      end
      OP_ANDI: aluop = ALUOP_AND;
      OP_ORI:  aluop = ALUOP_OR;
      OP_XORI: aluop = ALUOP_XOR;
      OP_LW, OP_SW: begin
        aluop   = ALUOP_ADD;
        sextend = 1'b1;
      end
      OP_BEQ: begin
        aluop   = ALUOP_SUB;
        sextend = 1'b1;
      end
      OP_J:    aluop = ALUOP_ADD;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// bounds memory wait states and traps illegal instructions into a sticky HALT.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int WAIT_LIMIT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [3:0] aluop,
  output logic       sextend,
  output logic       halted
);

  // The counter only has to reach WAIT_LIMIT-1: the next not-ready cycle traps.
  localparam int WAIT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LIMIT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  ctrl_t             ctrl_q, ctrl_d;

  logic [3:0] dec_aluop;
  logic       dec_sextend;
  logic       dec_illegal;
  logic       fetch_done;

  multicycle_controller_alu_decoder u_alu_decoder (
    .op      (op),
    .funct   (funct),
    .aluop   (dec_aluop),
    .sextend (dec_sextend),
    .illegal (dec_illegal)
  );

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH, S_MEMRD, S_MEMWR: begin
        if (mem_ready) begin
          case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_MEMRD: state_d = S_MEMWB;
            default: state_d = S_FETCH;
          endcase
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          state_d = S_HALT;
        end else begin
          case (op)
            OP_RTYPE:                                   state_d = S_RTEXE;
            OP_LW, OP_SW:                               state_d = S_MEMADR;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: state_d = S_IEXE;
            OP_BEQ:                                     state_d = S_BRANCH;
            OP_J:                                       state_d = S_JUMP;
            default:                                    state_d = S_HALT;
          endcase
        end
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_RTEXE:  state_d = S_ALUWB;
      S_IEXE:   state_d = S_IWB;
      S_ALUWB, S_IWB, S_MEMWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_HALT;
    endcase
  end

  // Control word for the state being entered, so outputs come straight from flops.
  assign ctrl_d = state_ctrl(state_d, dec_aluop, dec_sextend);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      ctrl_q  <= ctrl_d;
    end
  end

  // IR load / PC increment and the branch decision react to inputs within the cycle.
  assign fetch_done = (state_q == S_FETCH) && mem_ready;

  assign pcen     = ctrl_q.pcen | fetch_done | ((state_q == S_BRANCH) && zero);
  assign irwrite  = ctrl_q.irwrite | fetch_done;
  assign iord     = ctrl_q.iord;
  assign memread  = ctrl_q.memread;
  assign memwrite = ctrl_q.memwrite;
  assign regdst   = ctrl_q.regdst;
  assign memtoreg = ctrl_q.memtoreg;
  assign regwrite = ctrl_q.regwrite;
  assign alusrca  = ctrl_q.alusrca;
  assign alusrcb  = ctrl_q.alusrcb;
  assign pcsrc    = ctrl_q.pcsrc;
  assign aluop    = ctrl_q.aluop;
  assign sextend  = ctrl_q.sextend;
  assign halted   = ctrl_q.halted;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller: full control vector
// compared every cycle against hand-derived expectations.
module tb_multicycle_controller;

  localparam int WAIT_LIMIT = 16;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pcen, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] aluop;
  logic       sextend, halted;

  always #5 clk = ~clk;

  multicycle_controller #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .op        (op),
    .funct     (funct),
    .zero      (zero),
    .mem_ready (mem_ready),
    .pcen      (pcen),
    .iord      (iord),
    .memread   (memread),
    .memwrite  (memwrite),
    .irwrite   (irwrite),
    .regdst    (regdst),
    .memtoreg  (memtoreg),
    .regwrite  (regwrite),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .pcsrc     (pcsrc),
    .aluop     (aluop),
    .sextend   (sextend),
    .halted    (halted)
  );

  typedef struct packed {
    logic       pcen, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [3:0] aluop;
    logic       sextend;
    logic       halted;
  } out_t;

  typedef struct {
    string      tag;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       rdy;
    out_t       exp;
  } vec_t;

  vec_t vecs[$];
  out_t act;
  int   n_checks = 0;
  int   n_fail   = 0;

  assign act = {pcen, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                alusrcb, pcsrc, aluop, sextend, halted};

  // Expected control words, written straight from the state descriptions.
  function automatic out_t e_fetch(input logic rdy);
    out_t o; o = '0;
    o.memread = 1'b1; o.alusrcb = 2'b01; o.aluop = 4'b0110; o.pcen = rdy; o.irwrite = rdy;
    return o;
  endfunction
  function automatic out_t e_decode();
    out_t o; o = '0;
    o.alusrcb = 2'b11; o.aluop = 4'b0110; o.sextend = 1'b1;
    return o;
  endfunction
  function automatic out_t e_rtexe(input logic [3:0] a);
    out_t o; o = '0;
    o.alusrca = 1'b1; o.alusrcb = 2'b00; o.aluop = a;
    return o;
  endfunction
  function automatic out_t e_aluwb();
    out_t o; o = '0;
    o.regwrite = 1'b1; o.regdst = 1'b1;
    return o;
  endfunction
  function automatic out_t e_iexe(input logic [3:0] a, input logic s);
    out_t o; o = '0;
    o.alusrca = 1'b1; o.alusrcb = 2'b10; o.aluop = a; o.sextend = s;
    return o;
  endfunction
  function automatic out_t e_iwb();
    out_t o; o = '0;
    o.regwrite = 1'b1;
    return o;
  endfunction
  function automatic out_t e_memadr();
    out_t o; o = '0;
    o.alusrca = 1'b1; o.alusrcb = 2'b10; o.aluop = 4'b0110; o.sextend = 1'b1;
    return o;
  endfunction
  function automatic out_t e_memrd();
    out_t o; o = '0;
    o.memread = 1'b1; o.iord = 1'b1;
    return o;
  endfunction
  function automatic out_t e_memwb();
    out_t o; o = '0;
    o.regwrite = 1'b1; o.memtoreg = 1'b1;
    return o;
  endfunction
  function automatic out_t e_memwr();
    out_t o; o = '0;
    o.memwrite = 1'b1; o.iord = 1'b1;
    return o;
  endfunction
  function automatic out_t e_branch(input logic z);
    out_t o; o = '0;
    o.alusrca = 1'b1; o.alusrcb = 2'b00; o.aluop = 4'b1110; o.pcsrc = 2'b01; o.pcen = z;
    return o;
  endfunction
  function automatic out_t e_jump();
    out_t o; o = '0;
    o.pcsrc = 2'b10; o.pcen = 1'b1;
    return o;
  endfunction
  function automatic out_t e_halt();
    out_t o; o = '0;
    o.halted = 1'b1;
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act_v[18:0], exp_v[18:0]);
    end
  endtask

  task automatic add(input string tag, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic r, input out_t e);
    vec_t v;
    v.tag = tag; v.op = o; v.funct = f; v.zero = z; v.rdy = r; v.exp = e;
    vecs.push_back(v);
  endtask

  // Called at posedge+1: drive inputs, compare at the falling edge, advance one cycle.
  task automatic apply(input string tag, input logic [5:0] o, input logic [5:0] f,
                       input logic z, input logic r, input out_t e);
    op = o; funct = f; zero = z; mem_ready = r;
    @(negedge clk);
    check(tag, 32'(act), 32'(e));
    @(posedge clk);
    #1;
  endtask

  // Assert reset away from the edge, check it acts at once, release at posedge+1.
  task automatic reset_dut(input string tag);
    reset_n = 1'b0;
    #1;
    check({tag, "_rst_async"}, 32'(act), 32'd0);
    @(negedge clk);
    check({tag, "_rst_hold"}, 32'(act), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] r_fn[7];
    logic [3:0] r_op[7];
    logic [5:0] i_opc[5];
    logic [3:0] i_alu[5];
    logic       i_sx[5];

    r_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010};
    r_op = '{4'b0110, 4'b1110, 4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1111};
    i_opc = '{6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001110};
    i_alu = '{4'b0110, 4'b1111, 4'b0000, 4'b0001, 4'b0010};
    i_sx  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    // ---- vector table: one row per clock cycle, starting in IDLE ----
    add("idle", 6'd0, 6'd0, 1'b1, 1'b1, '0);
    for (int i = 0; i < 7; i++) begin
      add($sformatf("r%0d_fetch", i),  6'd0, r_fn[i], 1'b0, 1'b1, e_fetch(1'b1));
      add($sformatf("r%0d_decode", i), 6'd0, r_fn[i], 1'b1, 1'b0, e_decode());
      add($sformatf("r%0d_exe", i),    6'd0, r_fn[i], 1'b1, 1'b0, e_rtexe(r_op[i]));
      add($sformatf("r%0d_wb", i),     6'd0, r_fn[i], 1'b1, 1'b1, e_aluwb());
    end
    for (int i = 0; i < 5; i++) begin
      add($sformatf("i%0d_fetch", i),  i_opc[i], 6'h3f, 1'b0, 1'b1, e_fetch(1'b1));
      add($sformatf("i%0d_decode", i), i_opc[i], 6'h3f, 1'b0, 1'b1, e_decode());
      add($sformatf("i%0d_exe", i),    i_opc[i], 6'h3f, 1'b0, 1'b0, e_iexe(i_alu[i], i_sx[i]));
      add($sformatf("i%0d_wb", i),     i_opc[i], 6'h3f, 1'b0, 1'b0, e_iwb());
    end
    add("sw_fetch_wait", 6'b101011, 6'd0, 1'b0, 1'b0, e_fetch(1'b0));
    add("sw_fetch",      6'b101011, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
    add("sw_decode",     6'b101011, 6'd0, 1'b0, 1'b1, e_decode());
    add("sw_memadr",     6'b101011, 6'd0, 1'b0, 1'b1, e_memadr());
    add("sw_memwr_wait", 6'b101011, 6'd0, 1'b0, 1'b0, e_memwr());
    add("sw_memwr",      6'b101011, 6'd0, 1'b0, 1'b1, e_memwr());
    add("lw_fetch",      6'b100011, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
    add("lw_decode",     6'b100011, 6'd0, 1'b0, 1'b0, e_decode());
    add("lw_memadr",     6'b100011, 6'd0, 1'b0, 1'b0, e_memadr());
    add("lw_memrd",      6'b100011, 6'd0, 1'b0, 1'b1, e_memrd());
    add("lw_memwb",      6'b100011, 6'd0, 1'b0, 1'b1, e_memwb());
    add("beq1_fetch",    6'b000100, 6'd0, 1'b1, 1'b1, e_fetch(1'b1));
    add("beq1_decode",   6'b000100, 6'd0, 1'b1, 1'b1, e_decode());
    add("beq1_branch",   6'b000100, 6'd0, 1'b1, 1'b0, e_branch(1'b1));
    add("beq0_fetch",    6'b000100, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
    add("beq0_decode",   6'b000100, 6'd0, 1'b0, 1'b1, e_decode());
    add("beq0_branch",   6'b000100, 6'd0, 1'b0, 1'b1, e_branch(1'b0));
    add("j_fetch",       6'b000010, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
    add("j_decode",      6'b000010, 6'd0, 1'b0, 1'b1, e_decode());
    add("j_jump",        6'b000010, 6'd0, 1'b0, 1'b0, e_jump());
    add("j_back_fetch",  6'b000010, 6'd0, 1'b0, 1'b0, e_fetch(1'b0));

    // ---- reset state ----
    reset_n = 1'b0; op = '0; funct = '0; zero = 1'b1; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(act), 32'd0);
    reset_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i].tag, vecs[i].op, vecs[i].funct, vecs[i].zero,
                            vecs[i].rdy, vecs[i].exp);

    // ---- LW with three MEMRD wait cycles: 8 cycles total, then FETCH ----
    apply("lww_fetch",  6'b100011, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
    apply("lww_decode", 6'b100011, 6'd0, 1'b0, 1'b0, e_decode());
    apply("lww_memadr", 6'b100011, 6'd0, 1'b0, 1'b0, e_memadr());
    for (int k = 0; k < 3; k++) apply($sformatf("lww_memrd_wait%0d", k),
                                      6'b100011, 6'd0, 1'b0, 1'b0, e_memrd());
    apply("lww_memrd",  6'b100011, 6'd0, 1'b0, 1'b1, e_memrd());
    apply("lww_memwb",  6'b100011, 6'd0, 1'b0, 1'b0, e_memwb());
    apply("lww_fetch2", 6'b100011, 6'd0, 1'b0, 1'b0, e_fetch(1'b0));

    // ---- unsupported opcode: sticky HALT until reset ----
    reset_dut("illop");
    apply("illop_idle",   6'h3f, 6'd0, 1'b0, 1'b1, '0);
    apply("illop_fetch",  6'h3f, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
    apply("illop_decode", 6'h3f, 6'd0, 1'b0, 1'b1, e_decode());
    for (int k = 0; k < 3; k++) apply($sformatf("illop_halt%0d", k),
                                      6'd0, 6'b100000, 1'b1, 1'b1, e_halt());

    // ---- R-type with unsupported funct ----
    reset_dut("illfn");
    apply("illfn_idle",   6'd0, 6'd0, 1'b0, 1'b1, '0);
    apply("illfn_fetch",  6'd0, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
    apply("illfn_decode", 6'd0, 6'd0, 1'b0, 1'b1, e_decode());
    for (int k = 0; k < 2; k++) apply($sformatf("illfn_halt%0d", k),
                                      6'b000010, 6'd0, 1'b1, 1'b1, e_halt());

    // ---- FETCH stuck not-ready: HALT after exactly WAIT_LIMIT cycles ----
    reset_dut("fto");
    apply("fto_idle", 6'd0, 6'd0, 1'b0, 1'b0, '0);
    for (int k = 1; k <= WAIT_LIMIT; k++) apply($sformatf("fto_wait%0d", k),
                                                6'd0, 6'd0, 1'b0, 1'b0, e_fetch(1'b0));
    apply("fto_halt0", 6'd0, 6'd0, 1'b0, 1'b1, e_halt());
    apply("fto_halt1", 6'd0, 6'd0, 1'b0, 1'b1, e_halt());

    // ---- ready on cycle 15 and on cycle 16 of FETCH: no halt ----
    for (int rc = WAIT_LIMIT - 1; rc <= WAIT_LIMIT; rc++) begin
      reset_dut($sformatf("frdy%0d", rc));
      apply("frdy_idle", 6'b000010, 6'd0, 1'b0, 1'b0, '0);
      for (int k = 1; k < rc; k++) apply($sformatf("frdy%0d_wait%0d", rc, k),
                                         6'b000010, 6'd0, 1'b0, 1'b0, e_fetch(1'b0));
      apply($sformatf("frdy%0d_fetch", rc),  6'b000010, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
      apply($sformatf("frdy%0d_decode", rc), 6'b000010, 6'd0, 1'b0, 1'b0, e_decode());
      apply($sformatf("frdy%0d_jump", rc),   6'b000010, 6'd0, 1'b0, 1'b0, e_jump());
      apply($sformatf("frdy%0d_back", rc),   6'b000010, 6'd0, 1'b0, 1'b0, e_fetch(1'b0));
    end

    // ---- MEMRD stuck not-ready: the counter restarts for the data access ----
    reset_dut("mto");
    apply("mto_idle",   6'b100011, 6'd0, 1'b0, 1'b0, '0);
    apply("mto_fetch_wait", 6'b100011, 6'd0, 1'b0, 1'b0, e_fetch(1'b0));
    apply("mto_fetch",  6'b100011, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
    apply("mto_decode", 6'b100011, 6'd0, 1'b0, 1'b0, e_decode());
    apply("mto_memadr", 6'b100011, 6'd0, 1'b0, 1'b0, e_memadr());
    for (int k = 1; k <= WAIT_LIMIT; k++) apply($sformatf("mto_wait%0d", k),
                                                6'b100011, 6'd0, 1'b0, 1'b0, e_memrd());
    apply("mto_halt", 6'b100011, 6'd0, 1'b0, 1'b1, e_halt());

    // ---- reset mid-store: write strobe drops at once, restart from IDLE ----
    reset_dut("mid");
    apply("mid_idle",   6'b101011, 6'd0, 1'b0, 1'b1, '0);
    apply("mid_fetch",  6'b101011, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));
    apply("mid_decode", 6'b101011, 6'd0, 1'b0, 1'b1, e_decode());
    apply("mid_memadr", 6'b101011, 6'd0, 1'b0, 1'b1, e_memadr());
    apply("mid_memwr",  6'b101011, 6'd0, 1'b0, 1'b0, e_memwr());
    mem_ready = 1'b1;
    reset_dut("mid");
    apply("mid_idle2",  6'b101011, 6'd0, 1'b0, 1'b1, '0);
    apply("mid_fetch2", 6'b101011, 6'd0, 1'b0, 1'b1, e_fetch(1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
